// File: rtl/pwm_leg_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_leg_capture_if
// Purpose  : Measurement handshake bundle between pwm_leg_capture and its
//            consumer. The producer drives MeasValid and the three counts.
//            The consumer drives MeasReady.
// Ports    : master - producer side (pwm_leg_capture)
//            slave  - consumer side
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_leg_capture_if #(
    parameter int BIT_WIDTH = 16
);
    logic                 MeasValid;
    logic                 MeasReady;
    logic [BIT_WIDTH-1:0] PeriodCount;
    logic [BIT_WIDTH-1:0] HighCount;
    logic [BIT_WIDTH-1:0] DeadCount;

    modport master (
        output MeasValid,
        output PeriodCount,
        output HighCount,
        output DeadCount,
        input  MeasReady
    );

    modport slave (
        input  MeasValid,
        input  PeriodCount,
        input  HighCount,
        input  DeadCount,
        output MeasReady
    );
endinterface
`default_nettype wire

// File: rtl/pwm_leg_capture.sv
`default_nettype none
// ============================================================================
// Module   : pwm_leg_capture
// Purpose  : Measures one complementary gate pair (SHigh/SLow). Once per PWM
//            period it reports the period, the high time and the dead time,
//            using a valid/ready handshake. It also keeps sticky
//            shoot-through, overrun and stall flags.
// Ports    : MClk, RstN        - clock, async active-low reset
//            SHigh, SLow       - asynchronous gate inputs
//            TimeoutCount      - max cycles between SHigh rises (0 = off)
//            FaultClear        - pulse, clears sticky flags
//            meas (master)     - MeasValid/MeasReady + Period/High/DeadCount
//            ShootThrough, Overrun, Stalled - sticky flags
// Options  : PWM_LEG_CAPTURE_DEADTIME_EN - builds the dead-time counter.
//            When undefined, DeadCount is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_leg_capture #(
    parameter int BIT_WIDTH  = 16,
    parameter int SyncStages = 2
) (
    input  logic                 MClk,
    input  logic                 RstN,
    input  logic                 SHigh,
    input  logic                 SLow,
    input  logic [BIT_WIDTH-1:0] TimeoutCount,
    input  logic                 FaultClear,
    pwm_leg_capture_if.master    meas,
    output logic                 ShootThrough,
    output logic                 Overrun,
    output logic                 Stalled
);
    localparam logic [0:0]           ST_IDLE    = 1'b0;
    localparam logic [0:0]           ST_MEASURE = 1'b1;
    localparam logic [BIT_WIDTH-1:0] CNT_MAX    = {BIT_WIDTH{1'b1}};
    localparam logic [BIT_WIDTH-1:0] CNT_ONE    = {{(BIT_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [BIT_WIDTH-1:0] sat_inc(input logic [BIT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // ---------------- synchronizers and edge detect ----------------
    logic [SyncStages-1:0] sh_sync_q, sh_sync_d, sl_sync_q, sl_sync_d;
    logic                  sh_prev_q, sh_prev_d;
    logic                  sh, sl, rise, timeout_hit;

    assign sh = sh_sync_q[SyncStages-1];
    assign sl = sl_sync_q[SyncStages-1];

    // ---------------- state and counters ----------------
    logic [0:0]           state_q, state_d;
    logic [BIT_WIDTH-1:0] period_q, period_d, high_q, high_d;
    logic [BIT_WIDTH-1:0] fin_period_q, fin_period_d, fin_high_q, fin_high_d;
    logic [BIT_WIDTH-1:0] out_period_q, out_period_d, out_high_q, out_high_d;
    logic                 done_q, done_d, valid_q, valid_d;
    logic                 st_q, st_d, ov_q, ov_d, stl_q, stl_d;
    logic                 restart, capture, count_en, stall_set, load;

    always_comb begin
        sh_sync_d   = {sh_sync_q[SyncStages-2:0], SHigh};
        sl_sync_d   = {sl_sync_q[SyncStages-2:0], SLow};
        sh_prev_d   = sh;
        rise        = sh & ~sh_prev_q;
        timeout_hit = (TimeoutCount != '0) && (period_q >= TimeoutCount);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (rise) state_d = ST_MEASURE;
            ST_MEASURE: if (!rise && timeout_hit) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: counter control strobes
    always_comb begin
        restart   = 1'b0;
        capture   = 1'b0;
        count_en  = 1'b0;
        stall_set = 1'b0;
        case (state_q)
            ST_IDLE:    restart = rise;
            ST_MEASURE: begin
                if (rise) begin
                    restart = 1'b1;
                    capture = 1'b1;
                end else if (timeout_hit) begin
                    stall_set = 1'b1;
                end else begin
                    count_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Running counters. The rise cycle starts the new period, and sh is 1 in
    // that cycle, so both period and high restart at one.
    always_comb begin
        period_d     = period_q;
        high_d       = high_q;
        if (restart) begin
            period_d = CNT_ONE;
            high_d   = CNT_ONE;
        end else if (count_en) begin
            period_d = sat_inc(period_q);
            if (sh) high_d = sat_inc(high_q);
        end
        fin_period_d = capture ? period_q : fin_period_q;
        fin_high_d   = capture ? high_q   : fin_high_q;
        done_d       = capture;
    end

    // Handshake: the finished period is offered one cycle after capture.
    always_comb begin
        load         = done_q & (~valid_q | meas.MeasReady);
        valid_d      = load ? 1'b1 : (meas.MeasReady ? 1'b0 : valid_q);
        out_period_d = load ? fin_period_q : out_period_q;
        out_high_d   = load ? fin_high_q   : out_high_q;
        // Sticky flags: a set in the same cycle as FaultClear wins.
        st_d  = (st_q  & ~FaultClear) | (sh & sl);
        ov_d  = (ov_q  & ~FaultClear) | (done_q & valid_q & ~meas.MeasReady);
        stl_d = (stl_q & ~FaultClear) | stall_set;
    end

    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            sh_sync_q    <= '0;
            sl_sync_q    <= '0;
            sh_prev_q    <= 1'b0;
            state_q      <= ST_IDLE;
            period_q     <= '0;
            high_q       <= '0;
            fin_period_q <= '0;
            fin_high_q   <= '0;
            out_period_q <= '0;
            out_high_q   <= '0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
            st_q         <= 1'b0;
            ov_q         <= 1'b0;
            stl_q        <= 1'b0;
        end else begin
            sh_sync_q    <= sh_sync_d;
            sl_sync_q    <= sl_sync_d;
            sh_prev_q    <= sh_prev_d;
            state_q      <= state_d;
            period_q     <= period_d;
            high_q       <= high_d;
            fin_period_q <= fin_period_d;
            fin_high_q   <= fin_high_d;
            out_period_q <= out_period_d;
            out_high_q   <= out_high_d;
            done_q       <= done_d;
            valid_q      <= valid_d;
            st_q         <= st_d;
            ov_q         <= ov_d;
            stl_q        <= stl_d;
        end
    end

`ifdef PWM_LEG_CAPTURE_DEADTIME_EN
    logic [BIT_WIDTH-1:0] dead_q, dead_d, fin_dead_q, fin_dead_d, out_dead_q, out_dead_d;

    // The rise cycle has sh = 1, so it never counts as dead time.
    always_comb begin
        dead_d = dead_q;
        if (restart)                    dead_d = '0;
        else if (count_en && !sh && !sl) dead_d = sat_inc(dead_q);
        fin_dead_d = capture ? dead_q : fin_dead_q;
        out_dead_d = load ? fin_dead_q : out_dead_q;
    end

    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            dead_q     <= '0;
            fin_dead_q <= '0;
            out_dead_q <= '0;
        end else begin
            dead_q     <= dead_d;
            fin_dead_q <= fin_dead_d;
            out_dead_q <= out_dead_d;
        end
    end

    assign meas.DeadCount = out_dead_q;
`else
    assign meas.DeadCount = '0;
`endif

    assign meas.MeasValid   = valid_q;
    assign meas.PeriodCount = out_period_q;
    assign meas.HighCount   = out_high_q;
    assign ShootThrough     = st_q;
    assign Overrun          = ov_q;
    assign Stalled          = stl_q;
endmodule
`default_nettype wire

// File: tb/tb_pwm_leg_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_leg_capture
// Purpose  : Self-checking bench for pwm_leg_capture. A 16-bit instance is
//            checked against a scoreboard fed from a vector table, plus
//            hand-written corner sequences. An 8-bit instance shares the gate
//            stimulus and is used for the saturation case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_leg_capture;
    logic        MClk = 1'b0;
    logic        RstN, SHigh, SLow, FaultClear;
    logic [15:0] TimeoutCount;
    logic [7:0]  TimeoutCount8;
    logic        st16, ov16, stl16, st8, ov8, stl8;
    logic        mon_en = 1'b0;
    int          errors = 0;
    int          checks = 0;

    always #5 MClk = ~MClk;

    pwm_leg_capture_if #(.BIT_WIDTH(16)) bus ();
    pwm_leg_capture_if #(.BIT_WIDTH(8))  bus8 ();

    pwm_leg_capture #(.BIT_WIDTH(16), .SyncStages(2)) dut (
        .MClk(MClk), .RstN(RstN), .SHigh(SHigh), .SLow(SLow),
        .TimeoutCount(TimeoutCount), .FaultClear(FaultClear), .meas(bus),
        .ShootThrough(st16), .Overrun(ov16), .Stalled(stl16)
    );

    pwm_leg_capture #(.BIT_WIDTH(8), .SyncStages(2)) dut8 (
        .MClk(MClk), .RstN(RstN), .SHigh(SHigh), .SLow(SLow),
        .TimeoutCount(TimeoutCount8), .FaultClear(FaultClear), .meas(bus8),
        .ShootThrough(st8), .Overrun(ov8), .Stalled(stl8)
    );

    typedef struct {
        int hi; int g1; int lo; int g2;
        int ep; int eh; int ed;
    } vec_t;

    typedef struct { int p; int h; int d; } meas_t;

    localparam int NVEC = 5;
    vec_t  vecs [NVEC];
    meas_t sbq  [$];

    function automatic int dead_exp(input int d);
`ifdef PWM_LEG_CAPTURE_DEADTIME_EN
        return d;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One PWM period: SHigh for hi cycles, g1 both low, SLow for lo, g2 both low.
    task automatic drive_period(input int hi, input int g1, input int lo, input int g2);
        SHigh = 1'b1; SLow = 1'b0; repeat (hi) @(negedge MClk);
        SHigh = 1'b0;              repeat (g1) @(negedge MClk);
        SLow  = 1'b1;              repeat (lo) @(negedge MClk);
        SLow  = 1'b0;              repeat (g2) @(negedge MClk);
    endtask

    task automatic push_exp(input int p, input int h, input int d);
        meas_t e;
        e.p = p; e.h = h; e.d = dead_exp(d);
        sbq.push_back(e);
    endtask

    // A final rise that closes the running period, then let the scoreboard drain.
    task automatic close_and_drain(input string name);
        SHigh = 1'b1; SLow = 1'b0; repeat (3) @(negedge MClk);
        SHigh = 1'b0;              repeat (10) @(negedge MClk);
        check(name, sbq.size(), 0);
    endtask

    task automatic reset_dut();
        RstN = 1'b0; SHigh = 1'b0; SLow = 1'b0; FaultClear = 1'b0;
        sbq.delete();
        repeat (2) @(negedge MClk);
        RstN = 1'b1;
        @(negedge MClk);
    endtask

    // Scoreboard monitor: every accepted measurement must match the queue head.
    always @(negedge MClk) begin
        if (mon_en && bus.MeasValid && bus.MeasReady) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got measurement period %0d expected none", bus.PeriodCount);
            end else begin
                meas_t e;
                e = sbq.pop_front();
                check("sb_period", bus.PeriodCount, e.p);
                check("sb_high",   bus.HighCount,   e.h);
                check("sb_dead",   bus.DeadCount,   e.d);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit found;
        vecs[0] = '{3, 1, 4, 1, 9, 3, 2};
        vecs[1] = '{2, 2, 3, 1, 8, 2, 3};
        vecs[2] = '{5, 1, 1, 1, 8, 5, 2};
        vecs[3] = '{1, 0, 1, 0, 2, 1, 0};
        vecs[4] = '{4, 2, 0, 3, 9, 4, 5};

        RstN = 1'b0; SHigh = 1'b0; SLow = 1'b0; FaultClear = 1'b0;
        TimeoutCount = 16'd0; TimeoutCount8 = 8'd0;
        bus.MeasReady = 1'b1; bus8.MeasReady = 1'b1;
        repeat (3) @(negedge MClk);
        check("reset_outputs", {bus.MeasValid, bus.PeriodCount, bus.HighCount, bus.DeadCount,
                                st16, ov16, stl16}, 0);
        RstN = 1'b1;
        @(negedge MClk);

        // ---- table-driven periods, MeasReady held high ----
        mon_en = 1'b1;
        drive_period(vecs[0].hi, vecs[0].g1, vecs[0].lo, vecs[0].g2);
        for (int i = 1; i < NVEC; i++) begin
            push_exp(vecs[i-1].ep, vecs[i-1].eh, vecs[i-1].ed);
            drive_period(vecs[i].hi, vecs[i].g1, vecs[i].lo, vecs[i].g2);
        end
        push_exp(vecs[NVEC-1].ep, vecs[NVEC-1].eh, vecs[NVEC-1].ed);
        close_and_drain("table_drained");
        check("table_no_shoot", st16, 0);
        mon_en = 1'b0;

        // ---- latency and MeasValid drop with ready held ----
        reset_dut();
        drive_period(3, 1, 4, 1);
        SHigh = 1'b1;
        repeat (3) @(negedge MClk);
        check("lat_valid_early", bus.MeasValid, 0);
        @(negedge MClk);
        check("lat_valid", bus.MeasValid, 1);
        check("lat_period", bus.PeriodCount, 9);
        check("lat_high", bus.HighCount, 3);
        check("lat_dead", bus.DeadCount, dead_exp(2));
        SHigh = 1'b0;
        @(negedge MClk);
        check("valid_drop", bus.MeasValid, 0);

        // ---- overrun with MeasReady low, then ready coinciding with a load ----
        reset_dut();
        bus.MeasReady = 1'b0;
        drive_period(3, 1, 4, 1);
        drive_period(2, 2, 3, 1);
        drive_period(4, 1, 2, 1);
        check("ovr_flag", ov16, 1);
        check("ovr_valid_held", bus.MeasValid, 1);
        check("ovr_period_held", bus.PeriodCount, 9);
        check("ovr_high_held", bus.HighCount, 3);
        check("ovr_dead_held", bus.DeadCount, dead_exp(2));
        SHigh = 1'b1;
        repeat (3) @(negedge MClk);
        bus.MeasReady = 1'b1;
        @(negedge MClk);
        check("ready_load_valid", bus.MeasValid, 1);
        check("ready_load_period", bus.PeriodCount, 8);
        check("ready_load_high", bus.HighCount, 4);
        SHigh = 1'b0;
        @(negedge MClk);
        check("ready_drop", bus.MeasValid, 0);
        check("ovr_sticky", ov16, 1);
        FaultClear = 1'b1;
        @(negedge MClk);
        FaultClear = 1'b0;
        check("ovr_cleared", ov16, 0);

        // ---- shoot-through ----
        reset_dut();
        SHigh = 1'b1; SLow = 1'b1;
        @(negedge MClk);
        SHigh = 1'b0; SLow = 1'b0;
        @(negedge MClk);
        check("st_sync_delay", st16, 0);
        @(negedge MClk);
        check("st_set", st16, 1);
        repeat (5) @(negedge MClk);
        check("st_sticky", st16, 1);
        FaultClear = 1'b1;
        @(negedge MClk);
        FaultClear = 1'b0;
        check("st_cleared", st16, 0);
        SHigh = 1'b1; SLow = 1'b1;
        @(negedge MClk);
        SHigh = 1'b0; SLow = 1'b0;
        @(negedge MClk);
        FaultClear = 1'b1;
        @(negedge MClk);
        FaultClear = 1'b0;
        check("st_set_wins", st16, 1);

        // ---- timeout ----
        reset_dut();
        TimeoutCount = 16'd20;
        mon_en = 1'b1;
        SHigh = 1'b1;
        repeat (3) @(negedge MClk);
        SHigh = 1'b0;
        repeat (19) @(negedge MClk);
        check("stall_early", stl16, 0);
        @(negedge MClk);
        check("stall_set", stl16, 1);
        repeat (5) @(negedge MClk);
        drive_period(3, 1, 4, 1);
        push_exp(9, 3, 2);
        close_and_drain("stall_rearm_drained");
        TimeoutCount = 16'd0;
        mon_en = 1'b0;

        // ---- saturation on the 8-bit instance, period 300 ----
        reset_dut();
        mon_en = 1'b1;
        drive_period(100, 50, 100, 50);
        push_exp(300, 100, 100);
        SHigh = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge MClk);
            if (bus8.MeasValid) begin
                found = 1'b1;
                check("sat_period8", bus8.PeriodCount, 255);
                check("sat_high8", bus8.HighCount, 100);
                check("sat_dead8", bus8.DeadCount, dead_exp(100));
            end
        end
        check("sat_valid_seen", found, 1);
        SHigh = 1'b0;
        repeat (5) @(negedge MClk);
        check("sat_drained", sbq.size(), 0);
        check("sat_no_stall8", stl8, 0);
        mon_en = 1'b0;

        // ---- reset mid-period with MeasValid held ----
        reset_dut();
        bus.MeasReady = 1'b0;
        drive_period(3, 1, 4, 1);
        SHigh = 1'b1;
        repeat (5) @(negedge MClk);
        check("rst_pre_valid", bus.MeasValid, 1);
        SHigh = 1'b0;
        RstN = 1'b0;
        #1;
        check("rst_async_outputs", {bus.MeasValid, bus.PeriodCount, bus.HighCount, bus.DeadCount,
                                    st16, ov16, stl16}, 0);
        repeat (2) @(negedge MClk);
        RstN = 1'b1;
        bus.MeasReady = 1'b1;
        sbq.delete();
        mon_en = 1'b1;
        drive_period(3, 1, 4, 1);
        push_exp(9, 3, 2);
        close_and_drain("rst_rearm_drained");
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pwm_leg_capture.md
# pwm_leg_capture

Measures one complementary gate-signal pair (one switch leg of the generated `S` bus) and reports period, high time and dead time once per PWM period. It also flags shoot-through and loss of switching. The block sits downstream of the PWM generator as its monitoring/receive end. It is used for closed-loop duty verification and protection, with one instance per monitored leg.

## Interface
- `BIT_WIDTH`, 16, width of all counters and measurement outputs
- `SyncStages`, 2, flip-flop synchronizer depth on `SHigh`/`SLow` (legal range 2..4)
- `MClk`  in  1  system clock; all logic on the rising edge
- `RstN`  in  1  asynchronous, active-low reset
- `SHigh`  in  1  high-side gate signal (asynchronous to `MClk`)
- `SLow`  in  1  low-side gate signal (asynchronous to `MClk`)
- `TimeoutCount`  in  BIT_WIDTH  maximum cycles allowed between `SHigh` rising edges; 0 disables the timeout
- `FaultClear`  in  1  single-cycle pulse; clears the sticky flags
- `MeasReady`  in  1  consumer ready
- `MeasValid`  out  1  measurement available
- `PeriodCount`  out  BIT_WIDTH  cycles from one synchronized `SHigh` rise to the next
- `HighCount`  out  BIT_WIDTH  cycles with synchronized `SHigh`=1 in that period
- `DeadCount`  out  BIT_WIDTH  cycles with both synchronized inputs 0 in that period
- `ShootThrough`  out  1  sticky flag: both inputs 1 were seen
- `Overrun`  out  1  sticky flag: a period completed while `MeasValid`=1 and `MeasReady`=0
- `Stalled`  out  1  sticky flag: the timeout expired

## Operation
- Both inputs pass through `SyncStages` flip-flops, followed by one more register for edge detection. All of the logic below uses the synchronized values `sh` and `sl`.
- **States:**
  - IDLE: waits for a rising edge on `sh`. On that edge: clear the running counters, preload the running period to 1, go to MEASURE.
  - MEASURE: each cycle, increment the running period, increment running-high if `sh`=1, and increment running-dead if `sh`=0 and `sl`=0.
    - On the next `sh` rise, latch the finished period and restart the counters at the rise cycle, so the rise cycle counts toward the new period.
- Running counters saturate at 2^BIT_WIDTH−1 and never wrap.
- **Timeout:** in MEASURE, if the running period reaches `TimeoutCount` (and `TimeoutCount`≠0), set `Stalled` and return to IDLE. No measurement is emitted.
- **Handshake (valid/ready):**
  - When a period completes and (`MeasValid`=0 or `MeasReady`=1), load the outputs and assert `MeasValid`.
  - `MeasValid` drops after a cycle with `MeasReady`=1, unless a new load occurs in that same cycle.
  - If a period completes while `MeasValid`=1 and `MeasReady`=0: outputs stay unchanged, the new measurement is discarded, and `Overrun` is set.
  - Outputs are stable while `MeasValid`=1.
- `ShootThrough` is set in any cycle where `sh`=1 and `sl`=1, in any state. Counting continues.
- `FaultClear` clears `ShootThrough`, `Overrun` and `Stalled`. If a set condition occurs in the same cycle as `FaultClear`, the set wins.
- `FaultClear` does not affect the state or `MeasValid`.

## Timing
- **Reset:** all outputs are 0, the state is IDLE, and the synchronizers are cleared to 0.
- **Latency:** an `SHigh` rise first sampled at edge k is seen as `sh`=1 after edge k+SyncStages−1. The resulting `MeasValid` and outputs update at edge k+SyncStages+1, i.e. 3 cycles for the default depth.
- The first `sh` rise after reset, or after a timeout, only arms the block and produces no measurement. The second rise produces the first measurement.
- Reset asserted mid-period discards the partial period.
- Inputs shorter than one `MClk` period may be missed; this is not detected.

## Configuration
- `PWM_LEG_CAPTURE_DEADTIME_EN`
  - Defined: the dead-time counter is built, and `DeadCount` behaves as described above.
  - Undefined: the counter is removed and `DeadCount` is tied to 0. All other behaviour is unchanged.

## Test plan
- `SHigh`=3 cycles high, then `SLow`=4 high, with 1 cycle both low on each side (period 9), held `MeasReady`=1 → from the second rise, one `MeasValid` pulse per period with `PeriodCount`=9, `HighCount`=3, `DeadCount`=2.
- Same stimulus with `MeasReady`=0 for 3 periods → the first measurement is held, `Overrun`=1, and the values still read 9/3/2. After `MeasReady`=1, `MeasValid` falls one cycle later unless a period completes in that cycle.
- Force `SHigh`=`SLow`=1 for 1 cycle → `ShootThrough`=1 after the synchronizer delay and stays set. A `FaultClear` pulse returns it to 0.
- `TimeoutCount`=20, stop toggling after one rise → `Stalled`=1 when the running period reaches 20, the state returns to IDLE, and no `MeasValid` occurs. The next two rises produce a valid measurement.
- `BIT_WIDTH`=8, period 300 cycles, `TimeoutCount`=0 → `PeriodCount`=255 (saturated) and `HighCount` is correct when under 255.
- Assert `RstN`=0 mid-period with `MeasValid`=1 → all outputs go to 0 immediately. After release, the first rise produces no measurement.
